pclk_phase_seq: RTL



---
 rtl/pclk_phase_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pclk_phase_seq.sv
// pclk_phase_seq: four-phase trapezoidal power-clock sequencer.
// It generates quantised level codes and per-phase state codes for four
// supply phases spaced one quarter apart. It also handles startup and
// graceful drain, so a phase never falls from a level it did not reach.
// Optional macro PCLK_FREEZE_EN adds a freeze input. While freeze is high,
// all sequencing state holds.
module pclk_phase_seq #(
  parameter int RAMP_STEPS = 8,
  parameter int STEP_CYC   = 4,
  parameter int CNT_W      = 16,
  localparam int LVL_W     = $clog2(RAMP_STEPS+1)
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef PCLK_FREEZE_EN
  input  logic               freeze,
`endif
  input  logic               run,
  output logic [4*LVL_W-1:0] lvl,
  output logic [7:0]         phs,
  output logic               qtick,
  output logic               busy,
  output logic [CNT_W-1:0]   cyc_cnt
);
  localparam int TW = (STEP_CYC   > 1) ? $clog2(STEP_CYC)   : 1;
  localparam int SW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(STEP_CYC-1);
  localparam logic [SW-1:0] S_MAX = SW'(RAMP_STEPS-1);
  localparam logic [1:0] PH_IDLE = 2'b00, PH_RISE = 2'b01,
                         PH_HOLD = 2'b10, PH_FALL = 2'b11;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

  state_t            r_state, w_nstate;
  logic [TW-1:0]     r_t, w_nt;
  logic [SW-1:0]     r_s, w_ns;
  logic [1:0]        r_q, w_nq, w_q_inc;
  logic [3:0]        r_arm, w_narm, w_arm_clr;
  logic [3:0][1:0]   w_xi, w_xn;
  logic              w_frz, w_active, w_start, w_qb;
  logic [4*LVL_W-1:0] w_lvl;
  logic [7:0]        w_phs;
  logic [1:0]        w_ph;

`ifdef PCLK_FREEZE_EN
  assign w_frz = freeze;
`else
  assign w_frz = 1'b0;
`endif

  assign w_active = (r_state != ST_STOP);
  assign w_start  = (r_state == ST_STOP) && run;
  assign w_qb     = w_active && (r_t == T_MAX) && (r_s == S_MAX);
  assign w_q_inc  = r_q + 2'd1;

  // Next-state: FSM, counters, arm bits, and the output codes they imply.
  always_comb begin
    // At a boundary, drop arm bits whose phase is scheduled into IDLE.
    // The DRAIN->STOP decision is based on what remains armed.
    w_arm_clr = r_arm;
    for (int k = 0; k < 4; k++) begin
      w_xi[k] = w_q_inc - 2'(k);
      if (w_qb && w_xi[k] == 2'd3) w_arm_clr[k] = 1'b0;
    end

    w_nstate = r_state;
    case (r_state)
      ST_STOP:  w_nstate = run ? ST_RUN : ST_STOP;
      ST_RUN:   w_nstate = run ? ST_RUN : ST_DRAIN;
      ST_DRAIN: begin
        if (run)                         w_nstate = ST_RUN;
        else if (w_qb && w_arm_clr == '0) w_nstate = ST_STOP;
        else                             w_nstate = ST_DRAIN;
      end
      default:  w_nstate = ST_STOP;
    endcase

    // A start sequence and a transition to STOP both zero the counters.
    if (w_nstate == ST_STOP || w_start) begin
      w_nt = '0;
      w_ns = '0;
      w_nq = '0;
    end else begin
      w_nt = (r_t == T_MAX) ? '0 : r_t + TW'(1);
      w_ns = (r_t == T_MAX) ? ((r_s == S_MAX) ? '0 : r_s + SW'(1)) : r_s;
      w_nq = w_qb ? w_q_inc : r_q;
    end

    // Arm only at a phase's own RISE boundary, and only in RUN.
    w_narm = r_arm;
    if (w_nstate == ST_STOP) w_narm = '0;
    else if (w_start)        w_narm = 4'b0001;
    else if (w_qb) begin
      w_narm = w_arm_clr;
      for (int k = 0; k < 4; k++)
        if (w_xi[k] == 2'd0 && w_nstate == ST_RUN) w_narm[k] = 1'b1;
    end

    // Scheduled slot x maps 0..3 to RISE,HOLD,FALL,IDLE, which is x+1 mod 4.
    w_lvl = '0;
    w_phs = '0;
    for (int k = 0; k < 4; k++) begin
      w_xn[k] = w_nq - 2'(k);
      w_ph    = w_narm[k] ? (w_xn[k] + 2'd1) : PH_IDLE;
      w_phs[2*k +: 2] = w_ph;
      case (w_ph)
        PH_RISE: w_lvl[k*LVL_W +: LVL_W] = LVL_W'(w_ns) + LVL_W'(1);
        PH_HOLD: w_lvl[k*LVL_W +: LVL_W] = LVL_W'(RAMP_STEPS);
        PH_FALL: w_lvl[k*LVL_W +: LVL_W] = LVL_W'(RAMP_STEPS-1) - LVL_W'(w_ns);
        default: w_lvl[k*LVL_W +: LVL_W] = '0;
      endcase
    end
  end

  // State and registered outputs. Freeze holds everything except qtick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STOP;
      r_t     <= '0;
      r_s     <= '0;
      r_q     <= '0;
      r_arm   <= '0;
      lvl     <= '0;
      phs     <= '0;
      qtick   <= 1'b0;
      busy    <= 1'b0;
      cyc_cnt <= '0;
    end else if (w_frz) begin
      qtick   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_t     <= w_nt;
      r_s     <= w_ns;
      r_q     <= w_nq;
      r_arm   <= w_narm;
      lvl     <= w_lvl;
      phs     <= w_phs;
      qtick   <= (w_nstate != ST_STOP) && (w_start || w_qb);
      busy    <= (w_nstate != ST_STOP);
      if (w_qb && r_q == 2'd3) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end
endmodule
